// File: rtl/arb_81_rr.sv
// arb_81_rr: round-robin arbiter and sequencer for the 8:1 selector datapath.
// Eight level requesters share one registered output (num/out) that is handed
// downstream with a valid/ready handshake.
// Optional feature: define ARB_81_LOCK_EN to add the 'lock' input. It lets the
// current owner keep the grant across transfers (burst ownership).
module arb_81_rr #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    req,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  input  logic [DW-1:0] data3,
  input  logic [DW-1:0] data4,
  input  logic [DW-1:0] data5,
  input  logic [DW-1:0] data6,
  input  logic [DW-1:0] data7,
  input  logic          out_ready,
`ifdef ARB_81_LOCK_EN
  input  logic          lock,
`endif
  output logic [2:0]    num,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic [7:0]    ack
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t        state;
  logic [2:0]    ptr;
  logic [DW-1:0] src [8];
  logic          xfer;
  logic          keep;
  logic [7:0]    arbreq;
  logic [2:0]    arbptr;
  logic [2:0]    winner;
  logic          anyreq;
  logic [2:0]    nextptr;

  // Gather the eight sources into an indexable array.
  always_comb begin
    src[0] = data0;
    src[1] = data1;
    src[2] = data2;
    src[3] = data3;
    src[4] = data4;
    src[5] = data5;
    src[6] = data6;
    src[7] = data7;
  end

  // A transfer happens whenever a held grant meets a ready consumer; ack names its owner.
  always_comb begin
    xfer    = out_valid && out_ready;
    ack     = xfer ? (8'd1 << num) : 8'd0;
    nextptr = num + 3'd1;
`ifdef ARB_81_LOCK_EN
    keep    = lock && req[num];
`else
    keep    = 1'b0;
`endif
  end

  // Choose the request set and starting priority: IDLE uses ptr, re-grant masks the served source.
  always_comb begin
    if (state == IDLE) begin
      arbreq = req;
      arbptr = ptr;
    end else begin
      arbreq = req & ~(8'd1 << num);
      arbptr = nextptr;
    end
    anyreq = |arbreq;
  end

  // Rotating priority search: the first set bit at arbptr, arbptr+1, ... wins.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    winner = 3'd0;
    found  = 1'b0;
    idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = arbptr + i[2:0];
      if (!found && arbreq[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Grant/hold state machine with registered num, out, out_valid and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      num       <= 3'd0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyreq) begin
            num       <= winner;
            out       <= src[winner];
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (xfer) begin
            if (keep) begin
              out <= src[num];
            end else begin
              ptr <= nextptr;
              if (anyreq) begin
                num <= winner;
                out <= src[winner];
              end else begin
                out_valid <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_81_rr.sv
// tb_arb_81_rr: directed and randomized bench for arb_81_rr, checked against a
// transaction-level model of the round-robin grant rules.
module tb_arb_81_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [3:0] data [8];
  logic       out_ready;
`ifdef ARB_81_LOCK_EN
  logic       lock;
`endif
  logic [2:0] num;
  logic [3:0] out;
  logic       out_valid;
  logic [7:0] ack;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic       mvalid;
  logic [2:0] mnum;
  logic [3:0] mout;
  int         mptr;

  arb_81_rr #(.DW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .data4(data[4]), .data5(data[5]), .data6(data[6]), .data7(data[7]),
    .out_ready(out_ready),
`ifdef ARB_81_LOCK_EN
    .lock(lock),
`endif
    .num(num), .out(out), .out_valid(out_valid), .ack(ack)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return 0;
  endfunction

  function automatic logic [7:0] model_ack();
    if (mvalid && out_ready) return 8'(1 << mnum);
    return 8'h00;
  endfunction

  task automatic model_reset();
    mvalid = 1'b0;
    mnum   = 3'd0;
    mout   = 4'h0;
    mptr   = 0;
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".num"}, 8'(num), 8'(mnum));
    cmp({tag, ".out"}, 8'(out), 8'(mout));
    cmp({tag, ".valid"}, 8'(out_valid), 8'(mvalid));
    cmp({tag, ".ack"}, ack, model_ack());
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
  endtask

  // One clock: inputs are already driven; check, predict, then advance past the edge.
  task automatic cycle(input string tag);
    logic       nvalid;
    logic [2:0] nnum;
    logic [3:0] nout;
    int         nptr;
    logic [7:0] masked;
    int         w;
    logic       lk;
    #1;
    checkOutput(tag);
    nvalid = mvalid; nnum = mnum; nout = mout; nptr = mptr;
`ifdef ARB_81_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    if (!mvalid) begin
      if (req != 8'h00) begin
        w = pick(req, mptr);
        nnum = 3'(w); nout = data[w]; nvalid = 1'b1;
      end
    end else if (out_ready) begin
      if (lk && req[mnum]) begin
        nout = data[mnum];
      end else begin
        nptr   = (int'(mnum) + 1) % 8;
        masked = req & ~(8'(1 << mnum));
        if (masked != 8'h00) begin
          w = pick(masked, nptr);
          nnum = 3'(w); nout = data[w];
        end else begin
          nvalid = 1'b0;
        end
      end
    end
    @(posedge clk);
    mvalid = nvalid; mnum = nnum; mout = nout; mptr = nptr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    req = 8'h00;
`ifdef ARB_81_LOCK_EN
    lock = 1'b0;
`endif
    foreach (data[i]) data[i] = 4'($urandom);
    model_reset();

    // Reset held with random activity on the inputs.
    applyStimulus(8'($urandom) | 8'h01, 1'b1);
    @(negedge clk);
    checkOutput("reset_a");
    foreach (data[i]) data[i] = 4'($urandom);
    applyStimulus(8'hFF, 1'b1);
    @(negedge clk);
    checkOutput("reset_b");
    rst_n = 1'b1;
    applyStimulus(8'h00, 1'b1);
    repeat (2) cycle("post_reset");

    // Single source 3.
    data[3] = 4'hA;
    applyStimulus(8'h08, 1'b1);
    cycle("single_req");
    cmp("single_num", 8'(num), 8'd3);
    cmp("single_out", 8'(out), 8'hA);
    cmp("single_ack", ack, 8'h08);
    applyStimulus(8'h00, 1'b1);
    cycle("single_xfer");
    cycle("single_idle");

    // Full load from reset: grants 0..7,0.
    do_reset();
    foreach (data[i]) data[i] = 4'(i);
    applyStimulus(8'hFF, 1'b1);
    cycle("full_first");
    for (int k = 0; k < 9; k++) begin
      #1;
      cmp("full_seq_out", 8'(out), 8'(k % 8));
      cmp("full_seq_ack", ack, 8'(1 << (k % 8)));
      cycle("full");
    end

    // Backpressure on source 5.
    do_reset();
    data[5] = 4'h3;
    applyStimulus(8'h20, 1'b0);
    cycle("bp_grant");
    data[5] = 4'hC;
    for (int k = 0; k < 4; k++) cycle("bp_hold");
    cmp("bp_out", 8'(out), 8'h3);
    applyStimulus(8'h20, 1'b1);
    #1;
    cmp("bp_ack", ack, 8'h20);
    applyStimulus(8'h00, 1'b1);
    cycle("bp_release");
    cycle("bp_idle");

    // Wrap: serve 6, then 0 must beat 6.
    do_reset();
    applyStimulus(8'h40, 1'b1);
    cycle("wrap_g6");
    applyStimulus(8'h00, 1'b1);
    cycle("wrap_x6");
    applyStimulus(8'h41, 1'b0);
    cycle("wrap_arb");
    cmp("wrap_num", 8'(num), 8'd0);

    // Asynchronous reset in the middle of HOLD.
    applyStimulus(8'h41, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("async_valid", 8'(out_valid), 8'd0);
    cmp("async_ack", ack, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h00, 1'b1);
    cycle("async_after");

`ifdef ARB_81_LOCK_EN
    // Burst ownership with lock.
    do_reset();
    lock = 1'b1;
    applyStimulus(8'h14, 1'b1);
    cycle("lock_grant");
    for (int k = 0; k < 4; k++) begin
      cmp("lock_num", 8'(num), 8'd2);
      cycle("lock_burst");
    end
    lock = 1'b0;
    cycle("lock_drop");
    cmp("lock_next", 8'(num), 8'd4);
`endif

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      foreach (data[i]) data[i] = 4'($urandom);
      applyStimulus(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), ($urandom_range(0, 3) != 0));
`ifdef ARB_81_LOCK_EN
      lock = ($urandom_range(0, 4) == 0);
`endif
      cycle("rand");
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
